// File: rtl/cw305_core_pkg.sv
// Shared types and constants for the CW305 iterative crypto core.
// Provides the FSM state enum and the round-index width.
package cw305_core_pkg;

  localparam int RND_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } core_state_e;

endpackage

// File: rtl/cw305_round.sv
// Combinational keyed round: s' = rotl(s^k, ROT) + zext(rnd), k' = rotl(k, 1).
// Ports: s, k, rnd in; s_nxt, k_nxt out. Parameters W, ROT.
module cw305_round
  import cw305_core_pkg::*;
#(
  parameter int W   = 128,
  parameter int ROT = 3
) (
  input  logic [W-1:0]     s,
  input  logic [W-1:0]     k,
  input  logic [RND_W-1:0] rnd,
  output logic [W-1:0]     s_nxt,
  output logic [W-1:0]     k_nxt
);

  logic [W-1:0] x;
  logic [W-1:0] x_rot;

  always_comb begin
    x     = s ^ k;
    // A shift by W yields zero, so ROT=0 degenerates cleanly.
    x_rot = (x << ROT) | (x >> (W - ROT));
    s_nxt = x_rot + W'(rnd);
    k_nxt = {k[W-2:0], k[W-1]};
  end

endmodule

// File: rtl/cw305_crypto_core.sv
// Iterative crypto core: one keyed round per clock, ct + done strobe at end.
// Ports: clk, resetn(sync, low), start, key, pt -> ct, busy, done
// [, trigger when CW305_CORE_TRIGGER_EN is defined].
module cw305_crypto_core
  import cw305_core_pkg::*;
#(
  parameter int W      = 128,
  parameter int ROUNDS = 10,
  parameter int ROT    = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [W-1:0] key,
  input  logic [W-1:0] pt,
  output logic [W-1:0] ct,
  output logic         busy,
  output logic         done
`ifdef CW305_CORE_TRIGGER_EN
  ,
  output logic         trigger
`endif
);

  localparam logic [RND_W-1:0] LAST = RND_W'(ROUNDS - 1);

  core_state_e      state_q, state_d;
  logic [W-1:0]     s_q, s_d;
  logic [W-1:0]     k_q, k_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [W-1:0]     ct_q, ct_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     s_nxt;
  logic [W-1:0]     k_nxt;

  cw305_round #(
    .W   (W),
    .ROT (ROT)
  ) u_round (
    .s     (s_q),
    .k     (k_q),
    .rnd   (rnd_q),
    .s_nxt (s_nxt),
    .k_nxt (k_nxt)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    rnd_d   = rnd_q;
    ct_d    = ct_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = pt;
          k_d     = key;
          rnd_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d   = s_nxt;
        k_d   = k_nxt;
        rnd_d = rnd_q + RND_W'(1);
        if (rnd_q == LAST) begin
          // Capture this round's result, not the stale s_q.
          ct_d    = s_nxt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      rnd_q   <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      rnd_q   <= rnd_d;
      ct_q    <= ct_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ct   = ct_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef CW305_CORE_TRIGGER_EN
  logic trig_q, trig_d;

  // Rises with the accepted start, falls with the final round.
  always_comb begin
    trig_d = trig_q;
    if (state_q == IDLE && start) begin
      trig_d = 1'b1;
    end else if (state_q == RUN && rnd_q == LAST) begin
      trig_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig_d;
    end
  end

  assign trigger = trig_q;
`endif

endmodule

// File: tb/tb_cw305_crypto_core.sv
// Directed bench for cw305_crypto_core: three instances
// (W=8/R=1, W=8/R=2, default) driven by one linear sequence.
module tb_cw305_crypto_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic         st1, st2, st3;
  logic [7:0]   k1, p1, k2, p2;
  logic [127:0] k3, p3;
  logic [7:0]   ct1, ct2;
  logic [127:0] ct3;
  logic         b1, b2, b3, d1, d2, d3;
`ifdef CW305_CORE_TRIGGER_EN
  logic         t1, t2, t3;
`endif

  int errors = 0;
  int checks = 0;
  int ndone;

  localparam logic [127:0] PA =
    128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] KA =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PB =
    128'hdeadbeef_00000000_ffffffff_12345678;
  localparam logic [127:0] PC =
    128'hffffffff_ffffffff_ffffffff_ffffffff;
  localparam logic [127:0] PD =
    128'h80000000_00000000_00000000_00000001;

  cw305_crypto_core #(.W(8), .ROUNDS(1), .ROT(1)) u1 (
    .clk(clk), .resetn(resetn), .start(st1),
    .key(k1), .pt(p1), .ct(ct1), .busy(b1), .done(d1)
`ifdef CW305_CORE_TRIGGER_EN
    , .trigger(t1)
`endif
  );

  cw305_crypto_core #(.W(8), .ROUNDS(2), .ROT(1)) u2 (
    .clk(clk), .resetn(resetn), .start(st2),
    .key(k2), .pt(p2), .ct(ct2), .busy(b2), .done(d2)
`ifdef CW305_CORE_TRIGGER_EN
    , .trigger(t2)
`endif
  );

  cw305_crypto_core u3 (
    .clk(clk), .resetn(resetn), .start(st3),
    .key(k3), .pt(p3), .ct(ct3), .busy(b3), .done(d3)
`ifdef CW305_CORE_TRIGGER_EN
    , .trigger(t3)
`endif
  );

  // Reference for W=128, ROUNDS=10, ROT=3.
  function automatic logic [127:0] ref_ct(
    input logic [127:0] p, input logic [127:0] kk);
    logic [127:0] s, k, x;
    s = p;
    k = kk;
    for (int r = 0; r < 10; r++) begin
      x = s ^ k;
      s = {x[124:0], x[127:125]} + 128'(r);
      k = {k[126:0], k[127]};
    end
    return s;
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run1(input logic [7:0] p, input logic [7:0] k,
                      input logic [7:0] e, input logic [7:0] prev);
    p1 = p; k1 = k; st1 = 1'b1;
    tick();
    chk("r1_busy_on", b1, 1'b1);
    chk("r1_done_lo", d1, 1'b0);
    chk("r1_ct_kept", ct1, prev);
    st1 = 1'b0; p1 = ~p; k1 = ~k;
    tick();
    chk("r1_busy_off", b1, 1'b0);
    chk("r1_done_hi", d1, 1'b1);
    chk("r1_ct", ct1, e);
    tick();
    chk("r1_done_fall", d1, 1'b0);
    chk("r1_ct_hold", ct1, e);
  endtask

  task automatic run2(input logic [7:0] p, input logic [7:0] k,
                      input logic [7:0] e, input logic [7:0] prev);
    p2 = p; k2 = k; st2 = 1'b1;
    tick();
    chk("r2_busy_c1", b2, 1'b1);
    chk("r2_ct_kept", ct2, prev);
    // Start pulse and new data mid-run must be ignored.
    p2 = ~p; k2 = ~k;
    tick();
    chk("r2_busy_c2", b2, 1'b1);
    chk("r2_done_lo", d2, 1'b0);
    chk("r2_ct_mid", ct2, prev);
    st2 = 1'b0;
    tick();
    chk("r2_busy_off", b2, 1'b0);
    chk("r2_done_hi", d2, 1'b1);
    chk("r2_ct", ct2, e);
    tick();
    chk("r2_done_fall", d2, 1'b0);
    chk("r2_no_requeue", b2, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    st1 = 0; st2 = 0; st3 = 0;
    k1 = 0; p1 = 0; k2 = 0; p2 = 0; k3 = 0; p3 = 0;
    tick();
    tick();
    chk("rst_ct1", ct1, 8'h00);
    chk("rst_ct2", ct2, 8'h00);
    chk("rst_ct3", ct3, 128'h0);
    chk("rst_busy", {b1, b2, b3}, 3'b000);
    chk("rst_done", {d1, d2, d3}, 3'b000);
`ifdef CW305_CORE_TRIGGER_EN
    chk("rst_trig", {t1, t2, t3}, 3'b000);
`endif
    resetn = 1'b1;
    tick();

    run1(8'h01, 8'h00, 8'h02, 8'h00);
    run1(8'hFF, 8'h0F, 8'hE1, 8'h02);

    run2(8'h01, 8'h00, 8'h05, 8'h00);
    run2(8'h80, 8'h80, 8'h03, 8'h05);
    run2(8'hFF, 8'h00, 8'h00, 8'h03);

    // Default: extra start pulses at N+3 and N+5 are dropped.
    p3 = PA; k3 = KA; st3 = 1'b1;
    tick();
    chk("d_busy_n", b3, 1'b1);
    st3 = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (d3) ndone++;
      chk("d_busy", b3, i < 10);
      chk("d_done", d3, i == 10);
      if (i == 10) chk("d_ct", ct3, ref_ct(PA, KA));
      st3 = (i == 2 || i == 4);
      p3  = (i == 2 || i == 4) ? PB : PA;
    end
    chk("d_ndone", ndone, 1);
    chk("d_ct_keep", ct3, ref_ct(PA, KA));

    // Reset mid-run aborts without done; ct returns to 0.
    p3 = PB; k3 = KA; st3 = 1'b1;
    tick();
    st3 = 1'b0;
    tick(); tick(); tick();
    resetn = 1'b0;
    tick();
    chk("ab_busy", b3, 1'b0);
    chk("ab_ct", ct3, 128'h0);
    chk("ab_done", d3, 1'b0);
    resetn = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (d3) ndone++;
    end
    chk("ab_no_done", ndone, 0);
    p3 = PB; k3 = KA; st3 = 1'b1;
    tick();
    st3 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("ab2_done", d3, i == 10);
    end
    chk("ab2_ct", ct3, ref_ct(PB, KA));

    // start held high: blocks repeat every 11 cycles.
    p3 = PC; k3 = KA; st3 = 1'b1;
    tick();
    for (int i = 1; i <= 22; i++) begin
      tick();
      chk("bb_done", d3, i == 10 || i == 21);
      chk("bb_busy", b3, !(i == 10 || i == 21));
      chk("bb_excl", b3 & d3, 1'b0);
`ifdef CW305_CORE_TRIGGER_EN
      chk("bb_trig", t3, b3);
`endif
      if (i == 10) begin
        chk("bb_ct1", ct3, ref_ct(PC, KA));
        p3 = PD;
      end
      if (i == 21) chk("bb_ct2", ct3, ref_ct(PD, KA));
    end
    st3 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
